cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the 8-bit CPU datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It generates one-cycle write strobes for the PC, instruction register and register file, and holds data-memory enables through a ready handshake. It replaces single-cycle control and adds halt, run/stop, a memory-wait watchdog and a retired-instruction counter.

---
 rtl/cpu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//
// Multi-cycle control FSM for the 8-bit CPU datapath. Each instruction is
// walked through FETCH, DECODE, then EXECUTE and/or MEMORY as needed, and
// finally WRITEBACK. The block issues one-cycle write strobes for the PC,
// the instruction register and the register file. It holds the data-memory
// enables for the whole of a ready handshake. It also provides a halt state,
// run/stop control, a memory-wait watchdog and a retired-instruction counter.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET          synchronous active-high reset
//   Run            level; permits fetching new instructions
//   OpCode         Instruction[15:13] (000-100 ALU, 101 LOAD, 110 STORE, 111 HALT)
//   AddressingMode Instruction[12]; 0 = immediate, 1 = ALU/memory result
//   MemReady       data memory completes its access on this edge
//   PCWriteEnable  one-cycle pulse when an instruction retires
//   IRWriteEnable  one-cycle pulse in FETCH
//   RegWriteEnable one-cycle pulse in WRITEBACK
//   MemReadEnable  held in MEMORY for a LOAD
//   MemWriteEnable held in MEMORY for a STORE
//   ResultSrc      1 = ALU result, 0 = memory data
//   Halted         high while in HALT
//   MemError       sticky; the memory watchdog expired
//   State          current state encoding
//   InstrCount     number of retired instructions (wraps)
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   Run,
  input  logic [2:0]             OpCode,
  input  logic                   AddressingMode,
  input  logic                   MemReady,
  output logic                   PCWriteEnable,
  output logic                   IRWriteEnable,
  output logic                   RegWriteEnable,
  output logic                   MemReadEnable,
  output logic                   MemWriteEnable,
  output logic                   ResultSrc,
  output logic                   Halted,
  output logic                   MemError,
  output logic [2:0]             State,
  output logic [COUNT_WIDTH-1:0] InstrCount
);

  localparam int WD_WIDTH = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(MEM_TIMEOUT - 1);

  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_UNUSED    = 3'd7
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              opCode_q, opCode_d;
  logic                    addrMode_q, addrMode_d;
  logic [WD_WIDTH-1:0]     wdogCount_q, wdogCount_d;
  logic                    memError_q, memError_d;
  logic [COUNT_WIDTH-1:0]  instrCount_q, instrCount_d;

  logic isLoadQ, isStoreQ, isAluQ;
  logic retire;

  // The class decode looks only at the latched opcode. This keeps it stable
  // after DECODE, while the instruction register may already be changing.
  assign isLoadQ  = (opCode_q == OP_LOAD);
  assign isStoreQ = (opCode_q == OP_STORE);
  assign isAluQ   = (opCode_q <= 3'b100);

  // State register plus the latched instruction fields, the watchdog,
  // the sticky error flag and the retire counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      opCode_q     <= 3'b000;
      addrMode_q   <= 1'b0;
      wdogCount_q  <= '0;
      memError_q   <= 1'b0;
      instrCount_q <= '0;
    end else begin
      state_q      <= state_d;
      opCode_q     <= opCode_d;
      addrMode_q   <= addrMode_d;
      wdogCount_q  <= wdogCount_d;
      memError_q   <= memError_d;
      instrCount_q <= instrCount_d;
    end
  end

  // Next-state and output decode. Strobes follow the state and the latched
  // opcode. The one exception is a STORE: it retires in MEMORY on the edge
  // its MemReady arrives, so the PC pulse there depends on MemReady.
  always_comb begin
    state_d        = state_q;
    opCode_d       = opCode_q;
    addrMode_d     = addrMode_q;
    wdogCount_d    = wdogCount_q;
    memError_d     = memError_q;
    instrCount_d   = instrCount_q;
    retire         = 1'b0;
    PCWriteEnable  = 1'b0;
    IRWriteEnable  = 1'b0;
    RegWriteEnable = 1'b0;
    MemReadEnable  = 1'b0;
    MemWriteEnable = 1'b0;
    ResultSrc      = 1'b0;
    Halted         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        IRWriteEnable = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        opCode_d    = OpCode;
        addrMode_d  = AddressingMode;
        wdogCount_d = '0;
        // STORE always goes to memory, whatever its mode bit says.
        if (OpCode == OP_HALT)       state_d = S_HALT;
        else if (OpCode == OP_STORE) state_d = S_MEMORY;
        else if (!AddressingMode)    state_d = S_WRITEBACK;
        else if (OpCode == OP_LOAD)  state_d = S_MEMORY;
        else                         state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        ResultSrc = 1'b1;
        state_d   = S_WRITEBACK;
      end
      S_MEMORY: begin
        MemReadEnable  = isLoadQ;
        MemWriteEnable = isStoreQ;
        // MemReady on the last allowed cycle still wins over the watchdog.
        if (MemReady) begin
          if (isStoreQ) retire  = 1'b1;
          else          state_d = S_WRITEBACK;
        end else if (wdogCount_q == WD_LAST) begin
          state_d    = S_HALT;
          memError_d = 1'b1;
        end else begin
          wdogCount_d = wdogCount_q + WD_WIDTH'(1);
        end
      end
      S_WRITEBACK: begin
        RegWriteEnable = 1'b1;
        ResultSrc      = isAluQ;
        retire         = 1'b1;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (retire) begin
      PCWriteEnable = 1'b1;
      instrCount_d  = instrCount_q + COUNT_WIDTH'(1);
      state_d       = Run ? S_FETCH : S_IDLE;
    end
  end

  assign State      = state_q;
  assign MemError   = memError_q;
  assign InstrCount = instrCount_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//
// Randomized and directed bench for cpu_sequencer. The stimulus tasks push
// one expected retirement record per instruction into a queue. The record
// holds the latency, the strobes, the memory-enable cycle counts and the new
// count value. The record is worked out from the opcode-class rules. A
// separate monitor pops a record every time the DUT pulses PCWriteEnable.
module tb_cpu_sequencer;

  localparam int MEM_TIMEOUT = 15;
  localparam int COUNT_WIDTH = 4;

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic                   Run;
  logic [2:0]             OpCode;
  logic                   AddressingMode;
  logic                   MemReady;
  logic                   PCWriteEnable;
  logic                   IRWriteEnable;
  logic                   RegWriteEnable;
  logic                   MemReadEnable;
  logic                   MemWriteEnable;
  logic                   ResultSrc;
  logic                   Halted;
  logic                   MemError;
  logic [2:0]             State;
  logic [COUNT_WIDTH-1:0] InstrCount;

  cpu_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .Run(Run),
    .OpCode(OpCode),
    .AddressingMode(AddressingMode),
    .MemReady(MemReady),
    .PCWriteEnable(PCWriteEnable),
    .IRWriteEnable(IRWriteEnable),
    .RegWriteEnable(RegWriteEnable),
    .MemReadEnable(MemReadEnable),
    .MemWriteEnable(MemWriteEnable),
    .ResultSrc(ResultSrc),
    .Halted(Halted),
    .MemError(MemError),
    .State(State),
    .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int latency;
    int regWr;
    int resSrc;
    int memRd;
    int memWr;
    int countAfter;
  } expT;

  expT expQ[$];
  expT monE;
  int  errors = 0;
  int  checks = 0;
  int  modelCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference rules: the latency counts FETCH through the retire cycle, and
  // w is the number of MEMORY cycles with MemReady low.
  function automatic expT predict(input logic [2:0] op, input logic mode, input int w);
    expT e;
    bit isLoad, isStore, isAlu;
    isLoad  = (op == 3'd5);
    isStore = (op == 3'd6);
    isAlu   = (op <= 3'd4);
    if (isStore)     e.latency = 3 + w;
    else if (!mode)  e.latency = 3;
    else if (isLoad) e.latency = 4 + w;
    else             e.latency = 4;
    e.regWr      = isStore ? 0 : 1;
    e.resSrc     = isAlu ? 1 : 0;
    e.memRd      = (isLoad && mode) ? w + 1 : 0;
    e.memWr      = isStore ? w + 1 : 0;
    e.countAfter = 0;
    return e;
  endfunction

  // Drives one non-HALT instruction. It is called at the start of a FETCH
  // cycle and returns one tick after the retire edge. The opcode bits are
  // scrambled once DECODE has passed, so the DUT must rely on its latched copy.
  task automatic applyStimulus(input logic [2:0] op, input logic mode, input int w,
                               input bit dropRun);
    expT e;
    int rem;
    e = predict(op, mode, w);
    modelCount = (modelCount + 1) % (1 << COUNT_WIDTH);
    e.countAfter = modelCount;
    expQ.push_back(e);
    OpCode = op;
    AddressingMode = mode;
    MemReady = 1'($urandom);
    tick();
    MemReady = 1'($urandom);
    tick();
    OpCode = 3'($urandom);
    AddressingMode = 1'($urandom);
    if (e.memRd > 0 || e.memWr > 0) begin
      for (int i = 0; i < w; i++) begin
        MemReady = 1'b0;
        tick();
      end
      MemReady = 1'b1;
      tick();
      if (e.memRd > 0) begin
        MemReady = 1'($urandom);
        tick();
      end
    end else begin
      rem = e.latency - 2;
      for (int i = 0; i < rem; i++) begin
        MemReady = 1'($urandom);
        if (dropRun && i == 0) Run = 1'b0;
        tick();
      end
    end
    MemReady = 1'b0;
  endtask

  // Monitor: it tracks cycles since IRWriteEnable and counts the memory-enable
  // cycles. On each PC pulse it checks the retirement against the next record.
  int  cyc = 0;
  int  startCyc = 0;
  int  rdCnt = 0;
  int  wrCnt = 0;
  bit  pendCnt = 1'b0;
  int  pendVal = 0;

  always @(negedge CLK) begin
    cyc++;
    if (pendCnt) begin
      checkOutput("instrCount", 32'(InstrCount), 32'(pendVal));
      pendCnt = 1'b0;
    end
    if (IRWriteEnable === 1'b1) begin
      startCyc = cyc;
      rdCnt = 0;
      wrCnt = 0;
    end
    if (MemReadEnable === 1'b1) rdCnt++;
    if (MemWriteEnable === 1'b1) wrCnt++;
    if (PCWriteEnable === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedRetire: PCWriteEnable=1 at cycle %0d, expected no retire", cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("latency", 32'(cyc - startCyc + 1), 32'(monE.latency));
        checkOutput("regWrite", 32'(RegWriteEnable), 32'(monE.regWr));
        checkOutput("resultSrc", 32'(ResultSrc), 32'(monE.resSrc));
        checkOutput("memReadCycles", 32'(rdCnt), 32'(monE.memRd));
        checkOutput("memWriteCycles", 32'(wrCnt), 32'(monE.memWr));
        pendCnt = 1'b1;
        pendVal = monE.countAfter;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0] op;
    int w;

    RESET = 1'b1;
    Run = 1'b0;
    OpCode = 3'b000;
    AddressingMode = 1'b0;
    MemReady = 1'b0;
    tick();
    tick();
    RESET = 1'b0;

    checkOutput("resetState", 32'(State), 32'd0);
    checkOutput("resetStrobes", 32'({PCWriteEnable, IRWriteEnable, RegWriteEnable,
                                      MemReadEnable, MemWriteEnable}), 32'd0);
    checkOutput("resetResultSrc", 32'(ResultSrc), 32'd0);
    checkOutput("resetHalted", 32'(Halted), 32'd0);
    checkOutput("resetMemError", 32'(MemError), 32'd0);
    checkOutput("resetCount", 32'(InstrCount), 32'd0);

    // FETCH comes one cycle after Run is sampled high in IDLE.
    Run = 1'b1;
    tick();
    checkOutput("firstFetch", 32'(State), 32'd1);

    // After 17 immediate instructions the 4-bit counter has wrapped to 1.
    applyStimulus(3'b000, 1'b0, 0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(3'($urandom_range(0, 5)), 1'b0, 0, 1'b0);
    checkOutput("wrapCount", 32'(InstrCount), 32'd1);

    // LOAD from memory with two wait cycles.
    applyStimulus(3'b101, 1'b1, 2, 1'b0);

    // Random mix of ALU, LOAD and STORE instructions, some of them
    // finishing on the last permitted memory cycle.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 6));
      w = ($urandom_range(0, 5) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
      applyStimulus(op, 1'($urandom), w, 1'b0);
    end

    // Drop Run during EXECUTE: the instruction finishes and the FSM idles.
    applyStimulus(3'($urandom_range(0, 4)), 1'b1, 0, 1'b1);
    checkOutput("idleAfterRunDrop", 32'(State), 32'd0);
    Run = 1'b1;
    tick();
    checkOutput("fetchAfterRunRise", 32'(State), 32'd1);

    // STORE with MemReady on the final permitted cycle retires normally.
    applyStimulus(3'b110, 1'b0, MEM_TIMEOUT - 1, 1'b0);

    // STORE that never gets MemReady: the watchdog fires.
    OpCode = 3'b110;
    AddressingMode = 1'b1;
    tick();
    tick();
    OpCode = 3'b000;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      MemReady = 1'b0;
      tick();
    end
    checkOutput("watchdogState", 32'(State), 32'd6);
    checkOutput("watchdogMemError", 32'(MemError), 32'd1);
    checkOutput("watchdogHalted", 32'(Halted), 32'd1);
    checkOutput("watchdogCount", 32'(InstrCount), 32'(modelCount));
    for (int i = 0; i < 4; i++) begin
      Run = ~Run;
      tick();
      checkOutput("haltHoldsState", 32'(State), 32'd6);
    end
    RESET = 1'b1;
    Run = 1'b0;
    tick();
    RESET = 1'b0;
    modelCount = 0;
    checkOutput("resetFromHaltState", 32'(State), 32'd0);
    checkOutput("resetFromHaltHalted", 32'(Halted), 32'd0);
    checkOutput("resetFromHaltMemError", 32'(MemError), 32'd0);
    checkOutput("resetFromHaltCount", 32'(InstrCount), 32'd0);

    // HALT opcode goes through states 1, 2, 6 and ignores Run from then on.
    Run = 1'b1;
    OpCode = 3'b111;
    tick();
    checkOutput("haltOpFetch", 32'(State), 32'd1);
    tick();
    checkOutput("haltOpDecode", 32'(State), 32'd2);
    tick();
    checkOutput("haltOpState", 32'(State), 32'd6);
    checkOutput("haltOpHalted", 32'(Halted), 32'd1);
    for (int i = 0; i < 4; i++) begin
      Run = ~Run;
      tick();
      checkOutput("haltOpHolds", 32'(Halted), 32'd1);
    end
    RESET = 1'b1;
    Run = 1'b0;
    tick();
    RESET = 1'b0;
    checkOutput("haltOpResetState", 32'(State), 32'd0);
    checkOutput("haltOpResetHalted", 32'(Halted), 32'd0);

    // RESET during a LOAD memory wait aborts the instruction cleanly.
    Run = 1'b1;
    OpCode = 3'b101;
    AddressingMode = 1'b1;
    tick();
    tick();
    tick();
    MemReady = 1'b0;
    tick();
    checkOutput("memWaitRead", 32'(MemReadEnable), 32'd1);
    RESET = 1'b1;
    Run = 1'b0;
    tick();
    RESET = 1'b0;
    checkOutput("abortState", 32'(State), 32'd0);
    checkOutput("abortStrobes", 32'({PCWriteEnable, IRWriteEnable, RegWriteEnable,
                                      MemReadEnable, MemWriteEnable}), 32'd0);
    checkOutput("abortCount", 32'(InstrCount), 32'd0);

    tick();
    tick();
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
